// File: rtl/vigenere_pkg.sv
// Shared ASCII constants and character-class helpers for the Vigenere decoder.
package vigenere_pkg;

    localparam logic [7:0] UC_A      = 8'd65;
    localparam logic [7:0] UC_Z      = 8'd90;
    localparam logic [7:0] LC_A      = 8'd97;
    localparam logic [7:0] LC_Z      = 8'd122;
    localparam logic [5:0] ALPHA_LEN = 6'd26;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= UC_A) && (c <= UC_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= LC_A) && (c <= LC_Z);
    endfunction

    function automatic logic is_alpha(input logic [7:0] c);
        return is_upper(c) || is_lower(c);
    endfunction

    // Alphabet offset (0..25) of a letter, case-insensitive; callers ensure c is a letter.
    function automatic logic [4:0] letter_offset(input logic [7:0] c);
        logic [7:0] base;
        base = is_upper(c) ? UC_A : LC_A;
        return 5'(c - base);
    endfunction

endpackage

// File: rtl/vigenere_shift_comb.sv
// Combinational single-character Vigenere back-shift; case preserved, non-letters unchanged.
module vigenere_shift_comb
    import vigenere_pkg::*;
(
    input  logic [7:0] in_ch,
    input  logic [4:0] shift,
    output logic [7:0] out_ch
);

    logic [7:0] base;
    logic [5:0] off;
    logic [5:0] p;

    // Subtract the shift in 6-bit space; a set sign bit means the letter wrapped past 'A'.
    always_comb begin
        base   = UC_A;
        off    = '0;
        p      = '0;
        out_ch = in_ch;
        if (is_alpha(in_ch)) begin
            base = is_upper(in_ch) ? UC_A : LC_A;
            off  = 6'(in_ch - base);
            p    = off - {1'b0, shift};
            if (p[5]) begin
                p = p + ALPHA_LEN;
            end
            out_ch = base + {2'b00, p};
        end
    end

endmodule

// File: rtl/vigenere_decode.sv
// Streaming Vigenere decipher: runtime-loaded key, valid/ready in and out, one output register.
module vigenere_decode
    import vigenere_pkg::*;
#(
    parameter int unsigned KEY_MAX_LEN = 16,
    parameter int unsigned KEY_IDX_W   = $clog2(KEY_MAX_LEN)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 key_clear,
    input  logic                 key_load_valid,
    input  logic [7:0]           key_load_char,
    input  logic                 msg_restart,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char,
    output logic [KEY_IDX_W:0]   key_len,
    output logic                 key_full
);

    // Key stored as shift amounts (0..25) rather than raw ASCII.
    logic [4:0]           key_mem [KEY_MAX_LEN];

    logic [KEY_IDX_W:0]   key_len_q, key_len_d;
    logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_char_q, out_char_d;

    logic                 key_empty;
    logic                 key_full_w;
    logic                 load_ok;
    logic                 in_fire;
    logic [4:0]           cur_shift;
    logic [7:0]           decoded;
    logic [KEY_IDX_W:0]   idx_inc;

    assign key_empty  = (key_len_q == '0);
    assign key_full_w = (key_len_q == (KEY_IDX_W+1)'(KEY_MAX_LEN));
    assign load_ok    = key_load_valid && is_alpha(key_load_char) && !key_full_w;
    assign in_ready   = !out_valid_q || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign cur_shift  = key_empty ? 5'd0 : key_mem[key_idx_q];
    assign idx_inc    = {1'b0, key_idx_q} + (KEY_IDX_W+1)'(1);

    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;
    assign key_len    = key_len_q;
    assign key_full   = key_full_w;

    vigenere_shift_comb u_shift (
        .in_ch  (in_char),
        .shift  (cur_shift),
        .out_ch (decoded)
    );

    // Key length and index: clear > load > restart > stream advance.
    always_comb begin
        key_len_d = key_len_q;
        key_idx_d = key_idx_q;
        if (key_clear) begin
            key_len_d = '0;
            key_idx_d = '0;
        end else if (load_ok) begin
            key_len_d = key_len_q + (KEY_IDX_W+1)'(1);
            key_idx_d = '0;
        end else if (msg_restart) begin
            key_idx_d = '0;
        end else if (in_fire && is_alpha(in_char) && !key_empty) begin
            key_idx_d = (idx_inc == key_len_q) ? '0 : idx_inc[KEY_IDX_W-1:0];
        end
    end

    // Output stage: capture on input transfer, drop valid once consumed, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_char_d  = decoded;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_len_q   <= '0;
            key_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'd0;
        end else begin
            key_len_q   <= key_len_d;
            key_idx_q   <= key_idx_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
        end
    end

    // Key storage has no reset; entries beyond key_len are never read.
    always_ff @(posedge clock) begin
        if (load_ok && !key_clear) begin
            key_mem[key_len_q[KEY_IDX_W-1:0]] <= letter_offset(key_load_char);
        end
    end

endmodule

// File: tb/tb_vigenere_decode.sv
// Directed self-checking bench for vigenere_decode.
module tb_vigenere_decode;

    localparam int unsigned KEY_MAX_LEN = 16;
    localparam int unsigned KEY_IDX_W   = 4;

    logic                 clock;
    logic                 reset_n;
    logic                 key_clear;
    logic                 key_load_valid;
    logic [7:0]           key_load_char;
    logic                 msg_restart;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_char;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_char;
    logic [KEY_IDX_W:0]   key_len;
    logic                 key_full;

    int n_cmp  = 0;
    int n_fail = 0;

    vigenere_decode #(
        .KEY_MAX_LEN (KEY_MAX_LEN),
        .KEY_IDX_W   (KEY_IDX_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .key_clear      (key_clear),
        .key_load_valid (key_load_valid),
        .key_load_char  (key_load_char),
        .msg_restart    (msg_restart),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_char        (in_char),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_char       (out_char),
        .key_len        (key_len),
        .key_full       (key_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one character for one cycle and return the registered result just after the edge.
    task automatic send_char(input logic [7:0] c, output logic [7:0] got, output logic vld);
        @(negedge clock);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clock);
        #1;
        got      = out_char;
        vld      = out_valid;
        in_valid = 1'b0;
    endtask

    task automatic load_key(input string k);
        for (int i = 0; i < k.len(); i++) begin
            @(negedge clock);
            key_load_valid = 1'b1;
            key_load_char  = k[i];
        end
        @(negedge clock);
        key_load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        key_clear = 1'b1;
        @(negedge clock);
        key_clear = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        msg_restart = 1'b1;
        @(negedge clock);
        msg_restart = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_char !== 8'd0 || key_len !== '0 || key_full !== 1'b0
            || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b char=%h len=%0d full=%b rdy=%b, want 0 00 0 0 1",
                     out_valid, out_char, key_len, key_full, in_ready);
        end
    endtask

    task automatic test_lemon();
        string      cin;
        string      exp;
        logic [7:0] got;
        logic       vld;
        cin = "LXFOPV EF RNHR";
        exp = "ATTACK AT DAWN";
        pulse_clear();
        load_key("LEMON");
        n_cmp++;
        if (key_len !== 5'd5) begin
            n_fail++;
            $display("FAIL lemon_len: got %0d want 5", key_len);
        end
        for (int i = 0; i < cin.len(); i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL lemon[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
    endtask

    task automatic test_lowercase();
        string      cin;
        string      exp;
        logic [7:0] got;
        logic       vld;
        cin = "lxfopvefrnhr";
        exp = "attackatdawn";
        pulse_restart();
        for (int i = 0; i < cin.len(); i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL lower[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
        // Trailing 'o' decodes with key 'O' only if '!' left the index alone.
        cin = "LxF!o";
        exp = "AtT!a";
        pulse_restart();
        for (int i = 0; i < cin.len(); i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL mixed[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] cin [9];
        logic [7:0] exp [9];
        logic [7:0] got;
        logic       vld;
        pulse_clear();
        load_key("B");
        cin = '{8'h61, 8'h41, 8'h62, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h00, 8'hC1};
        exp = '{8'h7A, 8'h5A, 8'h61, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h00, 8'hC1};
        for (int i = 0; i < 9; i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_b[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
        pulse_clear();
        load_key("Z");
        cin[0:2] = '{8'h79, 8'h5A, 8'h7F};
        exp[0:2] = '{8'h7A, 8'h41, 8'h7F};
        for (int i = 0; i < 3; i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_z[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
    endtask

    task automatic test_empty_key();
        string      cin;
        logic [7:0] got;
        logic       vld;
        cin = "Hello, 123";
        pulse_clear();
        n_cmp++;
        if (key_len !== '0) begin
            n_fail++;
            $display("FAIL empty_len: got %0d want 0", key_len);
        end
        for (int i = 0; i < cin.len(); i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== cin[i]) begin
                n_fail++;
                $display("FAIL empty[%0d]: got %h valid %b, want %h", i, got, vld, cin[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        string      cin;
        string      exp;
        logic [7:0] got;
        logic       vld;
        cin = "LXF";
        exp = "ATT";
        load_key("LEMON");
        for (int i = 0; i < cin.len(); i++) begin
            send_char(cin[i], got, vld);
            n_cmp++;
            if (vld !== 1'b1 || got !== exp[i]) begin
                n_fail++;
                $display("FAIL bp_pre[%0d]: got %h valid %b, want %h", i, got, vld, exp[i]);
            end
        end
        // Offer 'O' (-> 'A') while the sink stalls on the held 'T'.
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = "O";
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_char !== "T") begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: rdy=%b valid=%b char=%h, want 0 1 54",
                         i, in_ready, out_valid, out_char);
            end
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_char !== "A") begin
            n_fail++;
            $display("FAIL bp_release: valid=%b char=%h, want 1 41", out_valid, out_char);
        end
        send_char("P", got, vld);
        n_cmp++;
        if (vld !== 1'b1 || got !== "C") begin
            n_fail++;
            $display("FAIL bp_after: got %h valid %b, want 43", got, vld);
        end
    endtask

    task automatic test_key_limits();
        logic [7:0] got;
        logic       vld;
        pulse_clear();
        load_key("7");
        n_cmp++;
        if (key_len !== '0) begin
            n_fail++;
            $display("FAIL nonletter_key: len %0d want 0", key_len);
        end
        load_key("ABCDEFGHIJKLMNOPQRS");
        load_key("7");
        n_cmp++;
        if (key_len !== 5'd16 || key_full !== 1'b1) begin
            n_fail++;
            $display("FAIL key_full: len %0d full %b, want 16 1", key_len, key_full);
        end
        // Shifts 0..15 on 'Z' end at 'K'; the 17th letter wraps back to shift 0.
        for (int i = 0; i < 17; i++) begin
            send_char("Z", got, vld);
            if (i == 15) begin
                n_cmp++;
                if (vld !== 1'b1 || got !== "K") begin
                    n_fail++;
                    $display("FAIL key_last: got %h valid %b, want 4b", got, vld);
                end
            end
        end
        n_cmp++;
        if (vld !== 1'b1 || got !== "Z") begin
            n_fail++;
            $display("FAIL key_wrap16: got %h valid %b, want 5a", got, vld);
        end
    endtask

    task automatic test_same_cycle_clear();
        logic [7:0] got;
        logic       vld;
        pulse_clear();
        load_key("B");
        @(negedge clock);
        in_valid  = 1'b1;
        in_char   = "b";
        key_clear = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        key_clear = 1'b0;
        n_cmp++;
        if (out_char !== "a" || key_len !== '0) begin
            n_fail++;
            $display("FAIL clear_same_cycle: char %h len %0d, want 61 0", out_char, key_len);
        end
        send_char("b", got, vld);
        n_cmp++;
        if (vld !== 1'b1 || got !== "b") begin
            n_fail++;
            $display("FAIL clear_after: got %h valid %b, want 62", got, vld);
        end
        // Hold the output, then clear the key: held character must survive.
        @(negedge clock);
        out_ready = 1'b0;
        load_key("C");
        send_char("d", got, vld);
        pulse_clear();
        n_cmp++;
        if (out_valid !== 1'b1 || out_char !== "b") begin
            n_fail++;
            $display("FAIL clear_hold: valid %b char %h, want 1 62", out_valid, out_char);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        logic [7:0] got;
        logic       vld;
        load_key("KEY");
        @(negedge clock);
        out_ready = 1'b0;
        send_char("Q", got, vld);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_char !== 8'd0 || key_len !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid %b char %h len %0d, want 0 00 0",
                     out_valid, out_char, key_len);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        key_clear      = 1'b0;
        key_load_valid = 1'b0;
        key_load_char  = 8'd0;
        msg_restart    = 1'b0;
        in_valid       = 1'b0;
        in_char        = 8'd0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        test_reset();
        test_lemon();
        test_lowercase();
        test_wrap();
        test_empty_key();
        test_backpressure();
        test_key_limits();
        test_same_cycle_clear();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vigenere_decode.md
Name: vigenere_decode

Overview:
Streaming ASCII Vigenère decipher. It sits on the receive side of a text path and inverts a Vigenère encoder that uses a runtime-loaded key.
- Each letter is shifted back by the current key letter; case is preserved; non-letters pass through unchanged.
- Valid/ready handshakes on input and output, with a single registered output stage.

Parameters:
KEY_MAX_LEN, 16, maximum key length in characters (2..64).
KEY_IDX_W, $clog2(KEY_MAX_LEN), width of key index/length counters.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
key_clear  input  1  sync pulse; empties key (key_len=0) and zeroes key index.
key_load_valid  input  1  key character strobe.
key_load_char  input  8  ASCII key character; only A-Z/a-z are stored.
msg_restart  input  1  sync pulse; zeroes key index (start of new message).
in_valid  input  1  ciphertext character valid.
in_ready  output  1  block can accept in_char this cycle.
in_char  input  8  ciphertext ASCII.
out_valid  output  1  out_char holds a decoded character.
out_ready  input  1  downstream accepts out_char.
out_char  output  8  plaintext ASCII.
key_len  output  KEY_IDX_W+1  number of stored key letters.
key_full  output  1  key_len == KEY_MAX_LEN.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_char=8'd0, key_len=0, key index=0, key storage contents don't-care. in_ready=1 right after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input transfer when in_valid && in_ready; the decoded character is registered and out_valid=1 next cycle (latency 1).
  - Output transfer when out_valid && out_ready; with no new input that cycle, out_valid clears.
  - Under backpressure, out_char/out_valid are held stable.
  - Full throughput: 1 char/cycle with out_ready held high.
- Decode:
  - shift = key[idx] minus 'A' or 'a' (0..25).
  - For letter c: off = c - base (base 'A'=65 or 'a'=97); p = off - shift; if p<0 then p+26; out = base + p. Use 6-bit arithmetic; no value exceeds 0..25 after correction.
  - Non-letters (anything outside 65-90, 97-122, including bytes >=128) go out unchanged and do not advance idx.
  - Letters advance idx: idx+1, wrapping to 0 when idx+1 == key_len.
  - key_len==0: shift=0, all characters pass through, idx stays 0.
- Key load:
  - On key_load_valid with a letter and !key_full: store at position key_len, key_len+1, idx<=0.
  - Non-letters, or loads while key_full, are ignored silently.
- Priority within one cycle: key_clear > key_load > msg_restart > stream advance.
  - An input transfer in the same cycle as any of these still uses the key/idx value from before the edge for its own decode.
  - The idx update from the control input wins over the stream increment.
- Mid-operation resets:
  - reset_n assertion discards any held output.
  - key_clear does not disturb a held out_char.

Decomposition:
- Package vigenere_pkg: ASCII constants (UC_A=65, UC_Z=90, LC_A=97, LC_Z=122, ALPHA_LEN=26) and functions is_upper, is_lower, is_alpha.
- One natural sub-module: vigenere_shift_comb, purely combinational; inputs char[7:0] and shift[4:0], output decoded char. Keeps the top to key storage, counters and the output register.

Test Plan:
- Load "LEMON", send "LXFOPV EF RNHR" with out_ready=1 -> "ATTACK AT DAWN", one char per cycle, latency 1, key_len=5.
- Same key, lowercase "lxfopvefrnhr" after msg_restart -> "attackatdawn"; mixed "LxF!" -> "AtT!" with idx unchanged across '!'.
- Wrap:
  - key "B": 'a'->'z', 'A'->'Z', 'b'->'a'.
  - key "Z": 'y'->'z'.
  - Bytes 0x00, 0x7F, 0xC1 pass unchanged.
- Empty key (after key_clear): "Hello, 123" -> "Hello, 123".
- Backpressure: drop out_ready low for 4 cycles mid-stream -> in_ready=0, out_char stable, no lost or duplicated characters when out_ready returns.
- Key limits and reset:
  - Load KEY_MAX_LEN+3 letters -> key_len=16, key_full=1, extras ignored; loading '7' is ignored.
  - Assert reset_n low mid-stream -> out_valid=0, out_char=0, key_len=0 immediately (asynchronously).
